// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: length codes, FSM states,
// packed-slice widths and channel index type.
package mem_port_arbiter_pkg;

    localparam int K_ADDR_L = 32;
    localparam int K_DATA_L = 32;
    localparam int K_LEN_L  = 2;
    localparam int K_IDX_L  = 3;

    localparam logic [K_LEN_L-1:0] LEN_B = 2'b00;
    localparam logic [K_LEN_L-1:0] LEN_H = 2'b01;
    localparam logic [K_LEN_L-1:0] LEN_W = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    typedef logic [K_IDX_L-1:0] ch_idx_t;

    function automatic ch_idx_t idx_next(ch_idx_t i, int n);
        int nx;
        nx = int'(i) + 1;
        return (nx >= n) ? '0 : ch_idx_t'(nx);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick: combinational winner search over a request mask,
// starting at a given index and wrapping modulo N_CH.
module arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_CH = 3
) (
    input  logic [N_CH-1:0] req,
    input  ch_idx_t         start,
    output ch_idx_t         idx,
    output logic            valid
);

    always_comb begin
        logic [N_CH-1:0] rot;
        idx   = '0;
        valid = 1'b0;
        rot   = '0;
        for (int k = 0; k < N_CH; k++) begin
            rot = req >> ((int'(start) + k) % N_CH);
            if (!valid && rot[0]) begin
                valid = 1'b1;
                idx   = ch_idx_t'((int'(start) + k) % N_CH);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel memory port arbiter with per-channel flush.
// ARB_RR_EN selects round-robin arbitration; SIM enables protocol assertions.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_CH   = 3,
    parameter int ADDR_L = K_ADDR_L,
    parameter int DATA_L = K_DATA_L,
    parameter int LEN_L  = K_LEN_L
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH-1:0]          ch_wr,
    input  logic [N_CH*ADDR_L-1:0]   ch_addr,
    input  logic [N_CH*LEN_L-1:0]    ch_len,
    input  logic [N_CH*DATA_L-1:0]   ch_wdata,
    input  logic [N_CH-1:0]          ch_flush,
    output logic [DATA_L-1:0]        ch_rdata,
    output logic [N_CH-1:0]          ch_ack,
    output logic                     m_re,
    output logic                     m_we,
    output logic [ADDR_L-1:0]        m_addr,
    output logic [LEN_L-1:0]         m_len,
    output logic [DATA_L-1:0]        m_dout,
    input  logic [DATA_L-1:0]        m_din,
    input  logic                     m_ack,
    output logic                     busy
);

    arb_state_t      state, state_nx;
    ch_idx_t         grant, pick_idx, start;
    logic            pick_vld;
    logic            drop;
    logic [N_CH-1:0] req_m, gnt_oh, wr_sh;
    logic            gnt_flush, sel_wr;
    logic [ADDR_L-1:0] sel_addr;
    logic [LEN_L-1:0]  sel_len;
    logic [DATA_L-1:0] sel_wdata;

    assign req_m     = ch_req & ~ch_flush;
    assign gnt_oh    = N_CH'(1) << grant;
    assign gnt_flush = |(ch_flush & gnt_oh);

    assign wr_sh     = ch_wr >> pick_idx;
    assign sel_wr    = wr_sh[0];
    assign sel_addr  = ADDR_L'(ch_addr >> (int'(pick_idx) * ADDR_L));
    assign sel_len   = LEN_L'(ch_len >> (int'(pick_idx) * LEN_L));
    assign sel_wdata = DATA_L'(ch_wdata >> (int'(pick_idx) * DATA_L));

`ifdef ARB_RR_EN
    ch_idx_t rr_ptr;

    // Pointer advances on every grant, even one later flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (state == ARB_IDLE && pick_vld)
            rr_ptr <= idx_next(pick_idx, N_CH);
    end

    assign start = rr_ptr;
`else
    assign start = '0;
`endif

    arb_pick #(
        .N_CH (N_CH)
    ) u_pick (
        .req   (req_m),
        .start (start),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ARB_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ARB_IDLE:    if (pick_vld) state_nx = ARB_ISSUE;
            ARB_ISSUE:   if (m_ack) state_nx = ARB_RELEASE;
            ARB_RELEASE: state_nx = ARB_IDLE;
            default:     state_nx = ARB_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ARB_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant    <= '0;
            drop     <= 1'b0;
            ch_ack   <= '0;
            ch_rdata <= '0;
            m_re     <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_len    <= '0;
            m_dout   <= '0;
        end else begin
            ch_ack <= '0;
            unique case (state)
                ARB_IDLE: begin
                    drop <= 1'b0;
                    if (pick_vld) begin
                        grant  <= pick_idx;
                        m_addr <= sel_addr;
                        m_len  <= sel_len;
                        m_dout <= sel_wdata;
                        m_re   <= ~sel_wr;
                        m_we   <= sel_wr;
                    end
                end
                ARB_ISSUE: begin
                    // A flush landing with m_ack still suppresses the ack.
                    if (m_ack) begin
                        m_re <= 1'b0;
                        m_we <= 1'b0;
                        drop <= 1'b0;
                        if (!(drop || gnt_flush)) begin
                            ch_ack <= gnt_oh;
                            if (m_re)
                                ch_rdata <= m_din;
                        end
                    end else if (gnt_flush) begin
                        drop <= 1'b1;
                    end
                end
                ARB_RELEASE: drop <= 1'b0;
                default:     drop <= 1'b0;
            endcase
        end
    end

`ifdef SIM
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(ch_ack))
                else $error("ch_ack has more than one bit set");
            if (state == ARB_ISSUE)
                assert ((|(gnt_oh & (ch_req | ch_flush))) || drop)
                    else $error("granted ch_req dropped during ISSUE");
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then random
// traffic, checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int N  = 3;
    localparam int AL = 32;
    localparam int DL = 32;
    localparam int LL = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      ch_req, ch_wr, ch_flush, ch_ack;
    logic [N*AL-1:0]   ch_addr;
    logic [N*LL-1:0]   ch_len;
    logic [N*DL-1:0]   ch_wdata;
    logic [DL-1:0]     ch_rdata, m_dout, m_din;
    logic              m_re, m_we, m_ack, busy;
    logic [AL-1:0]     m_addr;
    logic [LL-1:0]     m_len;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .N_CH   (N),
        .ADDR_L (AL),
        .DATA_L (DL),
        .LEN_L  (LL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_req   (ch_req),
        .ch_wr    (ch_wr),
        .ch_addr  (ch_addr),
        .ch_len   (ch_len),
        .ch_wdata (ch_wdata),
        .ch_flush (ch_flush),
        .ch_rdata (ch_rdata),
        .ch_ack   (ch_ack),
        .m_re     (m_re),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_len    (m_len),
        .m_dout   (m_dout),
        .m_din    (m_din),
        .m_ack    (m_ack),
        .busy     (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Requester agents and memory responder state
    logic [N-1:0]  req_v, wr_v, fl_set, auto_v, hold_off;
    logic [AL-1:0] addr_v [N];
    logic [LL-1:0] len_v  [N];
    logic [DL-1:0] wd_v   [N];
    int            ack_seen [N];
    bit            rand_mode, stray, acked;
    int            mem_lat, lat_cnt;
    logic [DL-1:0] din_set;

    task automatic set_req(int i, bit wr, logic [AL-1:0] a,
                           logic [LL-1:0] l, logic [DL-1:0] d);
        req_v[i]  = 1'b1;
        wr_v[i]   = wr;
        addr_v[i] = a;
        len_v[i]  = l;
        wd_v[i]   = d;
    endtask

    task automatic drive_ports();
        for (int i = 0; i < N; i++) begin
            ch_req[i]               = req_v[i];
            ch_wr[i]                = wr_v[i];
            ch_addr[i*AL +: AL]     = addr_v[i];
            ch_len[i*LL +: LL]      = len_v[i];
            ch_wdata[i*DL +: DL]    = wd_v[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ch_ack[i]) begin
                req_v[i]    = 1'b0;
                hold_off[i] = 1'b1;
                ack_seen[i]++;
            end else if (hold_off[i]) begin
                hold_off[i] = 1'b0;
                if (auto_v[i]) req_v[i] = 1'b1;
            end else if (rand_mode && !req_v[i] && $urandom_range(0, 3) == 0) begin
                set_req(i, 1'($urandom_range(0, 1)), $urandom,
                        LL'($urandom_range(0, 2)), $urandom);
            end
            if (rand_mode && $urandom_range(0, 19) == 0) fl_set[i] = 1'b1;
            ch_flush[i] = fl_set[i];
            if (fl_set[i]) req_v[i] = 1'b0;
            fl_set[i] = 1'b0;
        end
        m_ack = 1'b0;
        m_din = rand_mode ? DL'($urandom) : '0;
        if (m_re || m_we) begin
            if (!acked) begin
                if (lat_cnt == 0) begin
                    m_ack = 1'b1;
                    m_din = rand_mode ? DL'($urandom) : din_set;
                    acked = 1'b1;
                end else begin
                    lat_cnt--;
                end
            end
        end else begin
            acked   = 1'b0;
            lat_cnt = rand_mode ? $urandom_range(0, 3) : mem_lat;
            if (stray) begin
                m_ack = 1'b1;
                m_din = 32'hBAD0BAD0;
                stray = 1'b0;
            end
        end
        drive_ports();
    endtask

    task automatic wait_ack(string name, int i, int max);
        int s = ack_seen[i];
        int k = 0;
        while (ack_seen[i] == s && k < max) begin
            step();
            k++;
        end
        chk({name, "_ack_seen"}, 64'(ack_seen[i] != s), 64'd1);
    endtask

    task automatic drain(string name, int max);
        int k = 0;
        do begin
            step();
            k++;
        end while (!(req_v == '0 && !busy) && k < max);
        chk({name, "_drained"}, 64'(req_v == '0 && !busy), 64'd1);
    endtask

    // Transaction-level reference model and scoreboard
    typedef struct {
        int           due;
        logic [N-1:0] vec;
        logic [DL-1:0] rd;
        bit           upd;
    } ack_e;

    ack_e          ackq[$];
    int            grants[$];
    int            phase, cur, rr_start, cyc;
    bit            cur_wr, drop;
    logic [AL-1:0] cur_a;
    logic [LL-1:0] cur_l;
    logic [DL-1:0] cur_d, exp_rd;

    function automatic int pick(logic [N-1:0] m, int s);
        for (int k = 0; k < N; k++)
            if (m[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    function automatic int gnt_at(int k);
        return (k < grants.size()) ? grants[k] : -1;
    endfunction

    always @(negedge clk) begin
        ack_e e;
        logic [N-1:0] m;
        int w;
        if (rst) begin
            phase    = 0;
            drop     = 1'b0;
            rr_start = 0;
            exp_rd   = '0;
            ackq.delete();
        end else begin
            cyc++;
            chk("busy", 64'(busy), 64'(phase != 0));
            if (phase == 1) begin
                chk("m_re", 64'(m_re), 64'(!cur_wr));
                chk("m_we", 64'(m_we), 64'(cur_wr));
                chk("m_addr", 64'(m_addr), 64'(cur_a));
                chk("m_len", 64'(m_len), 64'(cur_l));
                chk("m_dout", 64'(m_dout), 64'(cur_d));
            end else begin
                chk("m_re_off", 64'(m_re), 64'd0);
                chk("m_we_off", 64'(m_we), 64'd0);
            end
            if (ackq.size() > 0 && ackq[0].due == cyc) begin
                e = ackq.pop_front();
                chk("ch_ack", 64'(ch_ack), 64'(e.vec));
                if (e.upd) exp_rd = e.rd;
            end else begin
                chk("ch_ack_quiet", 64'(ch_ack), 64'd0);
            end
            chk("ch_rdata", 64'(ch_rdata), 64'(exp_rd));

            if (phase == 0) begin
                m = ch_req & ~ch_flush;
                if (m != '0) begin
                    w = pick(m, rr_start);
                    grants.push_back(w);
                    cur    = w;
                    cur_wr = ch_wr[w];
                    cur_a  = ch_addr[w*AL +: AL];
                    cur_l  = ch_len[w*LL +: LL];
                    cur_d  = ch_wdata[w*DL +: DL];
                    drop   = 1'b0;
                    phase  = 1;
`ifdef ARB_RR_EN
                    rr_start = (w + 1) % N;
`endif
                end
            end else if (phase == 1) begin
                if (ch_flush[cur]) drop = 1'b1;
                if (m_ack) begin
                    e.due = cyc + 1;
                    e.vec = drop ? '0 : N'(1 << cur);
                    e.rd  = m_din;
                    e.upd = !drop && !cur_wr;
                    ackq.push_back(e);
                    phase = 2;
                end
            end else begin
                phase = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g0;
        int k;
        req_v = '0; wr_v = '0; fl_set = '0; auto_v = '0; hold_off = '0;
        for (int i = 0; i < N; i++) begin
            addr_v[i] = '0; len_v[i] = '0; wd_v[i] = '0; ack_seen[i] = 0;
        end
        rand_mode = 0; stray = 0; acked = 0; mem_lat = 1; lat_cnt = 1;
        din_set = '0; m_ack = 1'b0; m_din = '0; ch_flush = '0;
        drive_ports();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_re", 64'(m_re), 64'd0);
        chk("rst_m_we", 64'(m_we), 64'd0);
        chk("rst_ch_ack", 64'(ch_ack), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdata", 64'(ch_rdata), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Contention on all three channels
        g0 = grants.size();
        set_req(0, 0, 32'h10, 2'b10, 0);
        set_req(1, 0, 32'h20, 2'b10, 0);
        set_req(2, 0, 32'h30, 2'b10, 0);
        drain("contend", 60);
        chk("contend_g0", 64'(gnt_at(g0)), 64'd0);
        chk("contend_g1", 64'(gnt_at(g0 + 1)), 64'd1);
        chk("contend_g2", 64'(gnt_at(g0 + 2)), 64'd2);

        // ch0 and ch2 re-request immediately after every ack
        g0 = grants.size();
        auto_v = 3'b101;
        set_req(0, 0, 32'h40, 2'b10, 0);
        set_req(2, 0, 32'h50, 2'b10, 0);
        k = 0;
        while (grants.size() < g0 + 4 && k < 80) begin
            step();
            k++;
        end
        auto_v = '0;
        drain("hold101", 80);
`ifdef ARB_RR_EN
        chk("hold_g0", 64'(gnt_at(g0)), 64'd0);
        chk("hold_g1", 64'(gnt_at(g0 + 1)), 64'd2);
        chk("hold_g2", 64'(gnt_at(g0 + 2)), 64'd0);
        chk("hold_g3", 64'(gnt_at(g0 + 3)), 64'd2);
`else
        chk("hold_g0", 64'(gnt_at(g0)), 64'd0);
        chk("hold_g1", 64'(gnt_at(g0 + 1)), 64'd0);
        chk("hold_g2", 64'(gnt_at(g0 + 2)), 64'd0);
        chk("hold_g3", 64'(gnt_at(g0 + 3)), 64'd0);
`endif

        // Single read on ch0
        mem_lat = 2;
        din_set = 32'hDEADBEEF;
        set_req(0, 0, 32'h100, 2'b10, 0);
        step();
        step();
        chk("rd_m_re", 64'(m_re), 64'd1);
        chk("rd_m_addr", 64'(m_addr), 64'h100);
        wait_ack("rd", 0, 20);
        chk("rd_ch_ack", 64'(ch_ack), 64'b001);
        chk("rd_rdata", 64'(ch_rdata), 64'hDEADBEEF);
        chk("rd_release", 64'(busy), 64'd1);
        step();
        chk("rd_idle", 64'(busy), 64'd0);

        // Flush of an in-flight read
        mem_lat = 3;
        din_set = 32'h12345678;
        set_req(0, 0, 32'h300, 2'b10, 0);
        step();
        step();
        chk("fl_issue", 64'(m_re), 64'd1);
        k = ack_seen[0];
        fl_set[0] = 1'b1;
        repeat (8) step();
        chk("fl_no_ack", 64'(ack_seen[0]), 64'(k));
        chk("fl_rdata", 64'(ch_rdata), 64'hDEADBEEF);
        chk("fl_idle", 64'(busy), 64'd0);

        // Write on ch1 with a slow memory
        mem_lat = 5;
        set_req(1, 1, 32'h2004, 2'b01, 32'hCAFEF00D);
        step();
        for (int j = 0; j < 5; j++) begin
            step();
            chk("wr_m_we", 64'(m_we), 64'd1);
            chk("wr_m_addr", 64'(m_addr), 64'h2004);
            chk("wr_m_dout", 64'(m_dout), 64'hCAFEF00D);
            chk("wr_m_len", 64'(m_len), 64'b01);
        end
        wait_ack("wr", 1, 20);
        chk("wr_ch_ack", 64'(ch_ack), 64'b010);
        chk("wr_rdata", 64'(ch_rdata), 64'hDEADBEEF);
        drain("wr", 10);

        // m_ack while idle is ignored
        stray = 1;
        step();
        step();
        chk("stray_idle", 64'(busy), 64'd0);

        // Random traffic with random flushes and latencies
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        drain("rand", 200);

        // Asynchronous reset in the middle of ISSUE
        mem_lat = 8;
        set_req(0, 0, 32'h500, 2'b10, 0);
        step();
        step();
        step();
        chk("ar_pre", 64'(m_re), 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        req_v = '0;
        hold_off = '0;
        m_ack = 1'b0;
        drive_ports();
        #1;
        chk("ar_m_re", 64'(m_re), 64'd0);
        chk("ar_m_we", 64'(m_we), 64'd0);
        chk("ar_ch_ack", 64'(ch_ack), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_rdata", 64'(ch_rdata), 64'd0);
        acked = 0;
        mem_lat = 1;
        @(posedge clk);
        #3 rst = 1'b0;

        din_set = 32'hA5A5A5A5;
        set_req(2, 0, 32'h400, 2'b10, 0);
        step();
        step();
        chk("post_m_re", 64'(m_re), 64'd1);
        chk("post_m_addr", 64'(m_addr), 64'h400);
        wait_ack("post", 2, 20);
        chk("post_ch_ack", 64'(ch_ack), 64'b100);
        chk("post_rdata", 64'(ch_rdata), 64'hA5A5A5A5);
        drain("post", 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
